// File: rtl/mul_div_if.sv
// mul_div_if: request/response bundle for mul_div_unit.
//   master: requester side (drives flush, in_valid, op, operands, out_ready)
//   slave : unit side      (drives in_ready, out_valid, result)
interface mul_div_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] left_data;
  logic [WIDTH-1:0] right_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;

  modport master (
    output flush, in_valid, op, left_data, right_data, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  flush, in_valid, op, left_data, right_data, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 RV-M multiply/divide unit.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mul_div_if.slave (flush, in_valid/in_ready + op/operands,
//           out_valid/out_ready + result)
// Optional macro MUL_DIV_FAST_MUL_EN: multiplies use one combinational
// 2*WIDTH multiplier and finish in one cycle; divides stay iterative.
module mul_div_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic      clk,
  input  logic      rst_n,
  mul_div_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t               r_state;
  logic [2:0]           r_op;
  logic [2*WIDTH-1:0]   r_prod;     // mul: {partial, multiplier}; div: {rem, dividend/quotient}
  logic [WIDTH-1:0]     r_b;        // multiplicand / divisor magnitude
  logic                 r_neg_res;  // product / quotient must be negated
  logic                 r_neg_rem;  // remainder takes the dividend sign
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_result;
  logic                 r_out_valid;

  // Accept-side decode
  logic             w_l_signed, w_r_signed, w_sa, w_sb;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic             w_div_zero, w_ovf;
  logic [WIDTH-1:0] w_special;

  assign w_l_signed = (bus.op == 3'b001) || (bus.op == 3'b010) ||
                      (bus.op == 3'b100) || (bus.op == 3'b110);
  assign w_r_signed = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
  assign w_sa       = w_l_signed & bus.left_data[WIDTH-1];
  assign w_sb       = w_r_signed & bus.right_data[WIDTH-1];
  assign w_mag_a    = w_sa ? -bus.left_data  : bus.left_data;
  assign w_mag_b    = w_sb ? -bus.right_data : bus.right_data;

  assign w_div_zero = bus.op[2] && (bus.right_data == '0);
  assign w_ovf      = bus.op[2] && !bus.op[0] &&
                      (bus.left_data == {1'b1, {(WIDTH-1){1'b0}}}) &&
                      (bus.right_data == '1);
  // op[1] selects remainder for divide ops
  assign w_special  = w_div_zero ? (bus.op[1] ? bus.left_data : '1)
                                 : (bus.op[1] ? '0 : bus.left_data);

  // One iteration step
  logic [WIDTH:0]     w_add, w_shift, w_sub;
  logic [2*WIDTH-1:0] w_mul_nxt, w_div_nxt, w_step;

  assign w_add     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
  assign w_mul_nxt = r_prod[0] ? {w_add, r_prod[WIDTH-1:1]}
                               : {1'b0, r_prod[2*WIDTH-1:1]};
  // Restoring divide: bring down the next dividend bit, trial-subtract.
  // A borrow shows up in bit WIDTH because rem < divisor always holds.
  assign w_shift   = r_prod[2*WIDTH-1:WIDTH-1];
  assign w_sub     = w_shift - {1'b0, r_b};
  assign w_div_nxt = w_sub[WIDTH] ? {w_shift[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0}
                                  : {w_sub[WIDTH-1:0],   r_prod[WIDTH-2:0], 1'b1};
  assign w_step    = r_op[2] ? w_div_nxt : w_mul_nxt;

`ifdef MUL_DIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_prod;
  assign w_fast_prod = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
`endif

  // Sign correction and result select, applied once on entry to DONE
  function automatic logic [WIDTH-1:0] f_result(
    input logic [2:0]         op,
    input logic [2*WIDTH-1:0] p,
    input logic               neg_res,
    input logic               neg_rem
  );
    logic [2*WIDTH-1:0] pn;
    logic [WIDTH-1:0]   q, rm, res;
    pn = neg_res ? -p : p;
    q  = neg_res ? -p[WIDTH-1:0] : p[WIDTH-1:0];
    rm = neg_rem ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
    case (op)
      3'b000:                 res = p[WIDTH-1:0];   // low half is sign-agnostic
      3'b001, 3'b010, 3'b011: res = pn[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         res = q;
      default:                res = rm;
    endcase
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_prod      <= '0;
      r_b         <= '0;
      r_neg_res   <= 1'b0;
      r_neg_rem   <= 1'b0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else if (bus.flush) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.in_valid) begin
          r_op      <= bus.op;
          r_prod    <= {{WIDTH{1'b0}}, w_mag_a};
          r_b       <= w_mag_b;
          r_neg_res <= w_sa ^ w_sb;
          r_neg_rem <= w_sa;
          r_cnt     <= '0;
          if (w_div_zero || w_ovf) begin
            r_state     <= S_DONE;
            r_result    <= w_special;
            r_out_valid <= 1'b1;
`ifdef MUL_DIV_FAST_MUL_EN
          end else if (!bus.op[2]) begin
            r_state     <= S_DONE;
            r_result    <= f_result(bus.op, w_fast_prod, w_sa ^ w_sb, w_sa);
            r_out_valid <= 1'b1;
`endif
          end else begin
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_prod <= w_step;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH-1)) begin
            r_state     <= S_DONE;
            r_result    <= f_result(r_op, w_step, r_neg_res, r_neg_rem);
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: if (bus.out_ready) begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  mul_div_if #(.WIDTH(32)) bus();

  mul_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

`ifdef MUL_DIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op, measure latency from the accept edge, check result, retire it.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string tag);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = op; bus.left_data = a; bus.right_data = b;
    @(posedge clk);
    #1 bus.in_valid = 1'b0; bus.left_data = $urandom; bus.right_data = $urandom;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.out_valid && n < 200);
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk(tag, 64'(bus.result), 64'(exp));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    chk({tag, " retire"}, {62'b0, bus.out_valid, bus.in_ready}, 64'b01);
  endtask

  initial begin
    int  n;
    logic seen;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.op = 3'b000;
    bus.left_data = '0; bus.right_data = '0; bus.out_ready = 1'b0;

    // Reset state
    #12;
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset result",    64'(bus.result),    64'd0);
    chk("reset in_ready",  64'(bus.in_ready),  64'd1);
    @(negedge clk); rst_n = 1'b1;

    // Multiplies
    run_op(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT, "MUL 7*-3");
    run_op(3'b001, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, MUL_LAT, "MULH");
    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, MUL_LAT, "MULHSU");
    run_op(3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, MUL_LAT, "MULHU");

    // Divides
    run_op(3'b100, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA, 33, "DIV -20/3");
    run_op(3'b110, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, 33, "REM -20/3");
    run_op(3'b101, 32'd20,       32'd3, 32'd6,        33, "DIVU 20/3");
    run_op(3'b111, 32'd20,       32'd3, 32'd2,        33, "REMU 20/3");

    // Special cases
    run_op(3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1, "DIV 5/0");
    run_op(3'b111, 32'd5,        32'd0,        32'd5,        1, "REMU 5/0");
    run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "DIV ovf");
    run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, "REM ovf");

    // Backpressure: DIVU 100/7 held for 10 cycles, a competing request presented
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 3'b101; bus.left_data = 32'd100; bus.right_data = 32'd7;
    @(posedge clk);
    #1 bus.op = 3'b000; bus.left_data = 32'd3; bus.right_data = 32'd3;  // keep in_valid high
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.out_valid && n < 200);
    chk("DIVU 100/7 latency", 64'(n), 64'd33);
    for (int i = 0; i < 10; i++) begin
      chk("hold result",    64'(bus.result),    64'd14);
      chk("hold out_valid", 64'(bus.out_valid), 64'd1);
      chk("hold in_ready",  64'(bus.in_ready),  64'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("after pulse in_ready",  64'(bus.in_ready),  64'd1);
    chk("after pulse out_valid", 64'(bus.out_valid), 64'd0);
    repeat (3) @(negedge clk);
    chk("no accept with out_ready", 64'(bus.in_ready), 64'd1);

    // Flush mid-DIV with a concurrent request
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 3'b100; bus.left_data = 32'd20; bus.right_data = 32'd3;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.op = 3'b101;
    bus.left_data = 32'd9; bus.right_data = 32'd0;
    @(posedge clk);
    #1 bus.flush = 1'b0; bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("flush no out_valid", 64'(seen), 64'd0);
    chk("flush in_ready",     64'(bus.in_ready), 64'd1);

    // Async reset mid-CALC
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 3'b000; bus.left_data = 32'd11; bus.right_data = 32'd13;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst mid out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst mid result",    64'(bus.result),    64'd0);
    chk("rst mid in_ready",  64'(bus.in_ready),  64'd1);
    @(negedge clk); rst_n = 1'b1;
    run_op(3'b101, 32'd20, 32'd3, 32'd6, 33, "DIVU after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
